// File: rtl/ft245_fifo_bridge.sv
// ft245_fifo_bridge: FT245 async FIFO pad bridge with TX/RX buffers, synchronisers and fair strobe FSM.
// Optional FT245_STATS_EN adds saturating pad read/write counters with stats_clr.
module ft245_fifo_bridge #(
  parameter int DATA_W      = 8,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RD_PULSE    = 4,
  parameter int WR_PULSE    = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_W-1:0]         pad_rdata,
  output logic [DATA_W-1:0]         pad_wdata,
  output logic                      pad_oe,
  input  logic                      pad_txe_n,
  input  logic                      pad_rxf_n,
  output logic                      pad_wr_n,
  output logic                      pad_rd_n,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level
`ifdef FT245_STATS_EN
  ,
  input  logic                      stats_clr,
  output logic [15:0]               rx_count,
  output logic [15:0]               tx_count
`endif
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int CA  = RD_PULSE > WR_PULSE ? RD_PULSE : WR_PULSE;
  localparam int CB  = SYNC_STAGES + 1 > TURN_CYCLES ? SYNC_STAGES + 1 : TURN_CYCLES;
  localparam int CW  = $clog2((CA > CB ? CA : CB) + 1);
  localparam int TW  = $clog2(TURN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RD_STROBE, TURN, WR_SETUP, WR_STROBE, WR_HOLD, HOLDOFF} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   last_rd_q, last_rd_d;
  logic [TW-1:0]          since_q;
  logic [SYNC_STAGES-1:0] txe_sync_q, rxf_sync_q;
  logic [DATA_W-1:0]      wdata_q, rdata_q;
  logic                   rx_pend_q;
  logic [DATA_W-1:0]      tx_mem [TX_DEPTH];
  logic [DATA_W-1:0]      rx_mem [RX_DEPTH];
  logic [TAW:0]           tx_wp_q, tx_rp_q;
  logic [RAW:0]           rx_wp_q, rx_rp_q;
  logic                   rd_ok, wr_ok, turn_ok, rd_last, wr_last, tx_push, rx_pop;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      txe_sync_q <= '1;
      rxf_sync_q <= '1;
    end else begin
      txe_sync_q <= {txe_sync_q[SYNC_STAGES-2:0], pad_txe_n};
      rxf_sync_q <= {rxf_sync_q[SYNC_STAGES-2:0], pad_rxf_n};
    end

  assign tx_level = tx_wp_q - tx_rp_q;
  assign rx_level = rx_wp_q - rx_rp_q;
  assign tx_ready = tx_level != (TAW+1)'(TX_DEPTH);
  assign rx_valid = rx_level != '0;
  assign rx_data  = rx_mem[rx_rp_q[RAW-1:0]];
  assign tx_push  = tx_valid & tx_ready;
  assign rx_pop   = rx_valid & rx_ready;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= tx_data;
    if (rx_pend_q) rx_mem[rx_wp_q[RAW-1:0]] <= rdata_q;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
    end else begin
      tx_wp_q <= tx_wp_q + (TAW+1)'(tx_push);
      tx_rp_q <= tx_rp_q + (TAW+1)'(wr_last);
      rx_wp_q <= rx_wp_q + (RAW+1)'(rx_pend_q);
      rx_rp_q <= rx_rp_q + (RAW+1)'(rx_pop);
    end

  assign rd_ok   = !rxf_sync_q[SYNC_STAGES-1] && rx_level != (RAW+1)'(RX_DEPTH);
  assign wr_ok   = !txe_sync_q[SYNC_STAGES-1] && tx_level != '0;
  assign turn_ok = since_q >= TW'(TURN_CYCLES - 1);
  assign rd_last = state_q == RD_STROBE && cnt_q == CW'(RD_PULSE - 1);
  assign wr_last = state_q == WR_STROBE && cnt_q == CW'(WR_PULSE - 1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    last_rd_d = last_rd_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rd_ok && (!wr_ok || !last_rd_q)) begin
          state_d   = RD_STROBE;
          last_rd_d = 1'b1;
        end else if (wr_ok) begin
          state_d   = turn_ok ? WR_SETUP : TURN;
          last_rd_d = 1'b0;
        end
      end
      RD_STROBE: if (rd_last) begin state_d = HOLDOFF; cnt_d = '0; end
      TURN:      if (turn_ok) state_d = WR_SETUP;
      WR_SETUP:  begin state_d = WR_STROBE; cnt_d = '0; end
      WR_STROBE: if (wr_last) begin state_d = WR_HOLD; cnt_d = '0; end
      WR_HOLD:   begin state_d = HOLDOFF; cnt_d = '0; end
      HOLDOFF:   if (cnt_q == CW'(SYNC_STAGES)) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // since_q counts RD#-high cycles after the last read, saturating once turnaround is satisfied
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
      since_q   <= TW'(TURN_CYCLES);
      wdata_q   <= '0;
      rdata_q   <= '0;
      rx_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
      since_q   <= rd_last ? '0 : since_q + TW'(since_q != TW'(TURN_CYCLES));
      rx_pend_q <= rd_last;
      if (rd_last) rdata_q <= pad_rdata;
      if (state_d == WR_SETUP && state_q != WR_SETUP) wdata_q <= tx_mem[tx_rp_q[TAW-1:0]];
    end

  assign pad_rd_n  = state_q != RD_STROBE;
  assign pad_wr_n  = state_q != WR_STROBE;
  assign pad_oe    = state_q inside {WR_SETUP, WR_STROBE, WR_HOLD};
  assign pad_wdata = wdata_q;

`ifdef FT245_STATS_EN
  logic [15:0] rx_count_q, tx_count_q;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else if (stats_clr) begin
      rx_count_q <= '0;
      tx_count_q <= '0;
    end else begin
      rx_count_q <= rx_count_q + 16'(rd_last && rx_count_q != 16'hFFFF);
      tx_count_q <= tx_count_q + 16'(wr_last && tx_count_q != 16'hFFFF);
    end

  assign rx_count = rx_count_q;
  assign tx_count = tx_count_q;
`endif
endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// tb_ft245_fifo_bridge: directed self-checking bench for ft245_fifo_bridge.
module tb_ft245_fifo_bridge;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pad_rdata = 8'h00;
  logic [7:0] pad_wdata;
  logic       pad_oe;
  logic       pad_txe_n = 1'b1;
  logic       pad_rxf_n = 1'b1;
  logic       pad_wr_n, pad_rd_n;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [4:0] tx_level, rx_level;
`ifdef FT245_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] rx_count, tx_count;
`endif
  int passed = 0;
  int total = 0;

  ft245_fifo_bridge dut (
    .clk(clk), .reset(reset), .pad_rdata(pad_rdata), .pad_wdata(pad_wdata), .pad_oe(pad_oe),
    .pad_txe_n(pad_txe_n), .pad_rxf_n(pad_rxf_n), .pad_wr_n(pad_wr_n), .pad_rd_n(pad_rd_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_level(tx_level), .rx_level(rx_level)
`ifdef FT245_STATS_EN
    , .stats_clr(stats_clr), .rx_count(rx_count), .tx_count(tx_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic push_tx(input logic [7:0] d);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pad_rd_n !== 1'b1) $display("FAIL reset_rd_n got %b want 1", pad_rd_n); else passed++;
    total++; if (pad_wr_n !== 1'b1) $display("FAIL reset_wr_n got %b want 1", pad_wr_n); else passed++;
    total++; if (pad_oe !== 1'b0) $display("FAIL reset_oe got %b want 0", pad_oe); else passed++;
    total++; if (pad_wdata !== 8'h00) $display("FAIL reset_wdata got %h want 00", pad_wdata); else passed++;
    total++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", tx_ready); else passed++;
    total++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else passed++;
    total++; if (tx_level !== 5'd0 || rx_level !== 5'd0)
      $display("FAIL reset_levels got tx=%0d rx=%0d want 0 0", tx_level, rx_level); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read;
    int n = 0, low = 0, lat;
    pad_rdata = 8'hA5;
    pad_rxf_n = 1'b0;
    while (pad_rd_n && n < 50) begin @(negedge clk); n++; end
    total++; if (n >= 50) $display("FAIL read_start timeout got rd_n=%b want 0", pad_rd_n); else passed++;
    pad_rxf_n = 1'b1;
    while (!pad_rd_n && low < 20) begin low++; @(negedge clk); end
    total++; if (low != 4) $display("FAIL read_pulse got %0d cycles want 4", low); else passed++;
    lat = low;
    while (!rx_valid && lat < 20) begin @(negedge clk); lat++; end
    total++; if (lat != 5) $display("FAIL read_latency got %0d want 5", lat); else passed++;
    total++; if (rx_data !== 8'hA5) $display("FAIL read_data got %h want a5", rx_data); else passed++;
    total++; if (rx_level !== 5'd1) $display("FAIL read_level got %0d want 1", rx_level); else passed++;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    total++; if (rx_level !== 5'd0 || rx_valid !== 1'b0)
      $display("FAIL read_pop got level=%0d valid=%b want 0 0", rx_level, rx_valid); else passed++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_write;
    int n = 0, low = 0, bad = 0;
    push_tx(8'h3C);
    total++; if (tx_level !== 5'd1) $display("FAIL write_push_level got %0d want 1", tx_level); else passed++;
    pad_txe_n = 1'b0;
    while (!pad_oe && n < 50) begin @(negedge clk); n++; end
    total++; if (n >= 50 || pad_wr_n !== 1'b1 || pad_wdata !== 8'h3C)
      $display("FAIL write_setup got oe=%b wr_n=%b wdata=%h want 1 1 3c", pad_oe, pad_wr_n, pad_wdata); else passed++;
    @(negedge clk);
    pad_txe_n = 1'b1;
    while (!pad_wr_n && low < 20) begin
      if (pad_wdata !== 8'h3C || !pad_oe) bad++;
      low++;
      @(negedge clk);
    end
    total++; if (low != 4) $display("FAIL write_pulse got %0d cycles want 4", low); else passed++;
    total++; if (bad != 0) $display("FAIL write_data_stable got %0d bad cycles want 0", bad); else passed++;
    total++; if (pad_oe !== 1'b1) $display("FAIL write_hold_oe got %b want 1", pad_oe); else passed++;
    @(negedge clk);
    total++; if (pad_oe !== 1'b0) $display("FAIL write_release_oe got %b want 0", pad_oe); else passed++;
    total++; if (tx_level !== 5'd0) $display("FAIL write_level got %0d want 0", tx_level); else passed++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_contention;
    bit   ev_rd [4];
    logic [7:0] wd [2];
    int   ne = 0, nw = 0, gap = 0, min_gap = 999;
    bit   counting = 0;
    logic prev_rd, prev_oe;
    push_tx(8'h11);
    push_tx(8'h22);
    push_tx(8'h33);
    rx_ready = 1'b1;
    pad_rxf_n = 1'b0;
    pad_txe_n = 1'b0;
    prev_rd = pad_rd_n;
    prev_oe = pad_oe;
    for (int c = 0; c < 400 && ne < 4; c++) begin
      @(negedge clk);
      if (prev_rd && !pad_rd_n) begin ev_rd[ne] = 1'b1; ne++; end
      if (!prev_oe && pad_oe) begin
        ev_rd[ne] = 1'b0;
        ne++;
        if (nw < 2) wd[nw] = pad_wdata;
        nw++;
        if (counting && gap < min_gap) min_gap = gap;
        counting = 0;
      end
      if (!prev_rd && pad_rd_n) begin counting = 1; gap = 0; end
      if (counting && !pad_oe) gap++;
      prev_rd = pad_rd_n;
      prev_oe = pad_oe;
    end
    pad_rxf_n = 1'b1;
    pad_txe_n = 1'b1;
    total++; if (ne != 4) $display("FAIL contend_events got %0d want 4", ne); else passed++;
    for (int i = 0; i < 4 && i < ne; i++) begin
      total++;
      if (ev_rd[i] !== (i % 2 == 0)) $display("FAIL contend_order[%0d] got rd=%b want %b", i, ev_rd[i], i % 2 == 0);
      else passed++;
    end
    total++; if (nw != 2 || wd[0] !== 8'h11 || wd[1] !== 8'h22)
      $display("FAIL contend_wdata got n=%0d %h %h want 2 11 22", nw, wd[0], wd[1]); else passed++;
    total++; if (min_gap < 2) $display("FAIL contend_turnaround got %0d want >=2", min_gap); else passed++;
    repeat (40) @(negedge clk);
    total++; if (tx_level !== 5'd1) $display("FAIL contend_tx_left got %0d want 1", tx_level); else passed++;
    rx_ready = 1'b0;
    total++; if (rx_level !== 5'd0) $display("FAIL contend_rx_drained got %0d want 0", rx_level); else passed++;
  endtask

  task automatic test_full_rx;
    int falls = 0;
    logic prev_rd;
    rx_ready = 1'b0;
    pad_rxf_n = 1'b0;
    prev_rd = pad_rd_n;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (prev_rd && !pad_rd_n) begin pad_rdata = 8'h40 + 8'(falls); falls++; end
      prev_rd = pad_rd_n;
    end
    total++; if (falls != 16) $display("FAIL full_reads got %0d want 16", falls); else passed++;
    total++; if (rx_level !== 5'd16 || tx_ready !== 1'b1)
      $display("FAIL full_level got %0d want 16", rx_level); else passed++;
    total++; if (rx_data !== 8'h40) $display("FAIL full_head got %h want 40", rx_data); else passed++;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    falls = 0;
    prev_rd = pad_rd_n;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (prev_rd && !pad_rd_n) falls++;
      prev_rd = pad_rd_n;
    end
    total++; if (falls != 1) $display("FAIL full_one_more got %0d want 1", falls); else passed++;
    total++; if (rx_level !== 5'd16 || rx_data !== 8'h41)
      $display("FAIL full_after_pop got level=%0d head=%h want 16 41", rx_level, rx_data); else passed++;
    pad_rxf_n = 1'b1;
    rx_ready = 1'b1;
    repeat (30) @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    int n = 0, strobes = 0;
    pad_txe_n = 1'b0;
    while (pad_wr_n && n < 60) begin @(negedge clk); n++; end
    total++; if (n >= 60) $display("FAIL midwr_start timeout got wr_n=%b want 0", pad_wr_n); else passed++;
    pad_txe_n = 1'b1;
    #1 reset = 1'b1;
    #1;
    total++; if (pad_wr_n !== 1'b1 || pad_oe !== 1'b0)
      $display("FAIL midwr_async got wr_n=%b oe=%b want 1 0", pad_wr_n, pad_oe); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx_level !== 5'd0 || rx_level !== 5'd0 || tx_ready !== 1'b1)
      $display("FAIL midwr_levels got tx=%0d rx=%0d want 0 0", tx_level, rx_level); else passed++;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!pad_wr_n || !pad_rd_n || pad_oe) strobes++;
    end
    total++; if (strobes != 0) $display("FAIL midwr_quiet got %0d active cycles want 0", strobes); else passed++;
  endtask

`ifdef FT245_STATS_EN
  task automatic test_stats;
    int falls = 0;
    logic prev_rd;
    rx_ready = 1'b1;
    pad_rxf_n = 1'b0;
    prev_rd = pad_rd_n;
    for (int c = 0; c < 200 && falls < 5; c++) begin
      @(negedge clk);
      if (prev_rd && !pad_rd_n) falls++;
      if (falls == 5) pad_rxf_n = 1'b1;
      prev_rd = pad_rd_n;
    end
    repeat (20) @(negedge clk);
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    pad_txe_n = 1'b0;
    for (int c = 0; c < 200 && tx_level != 0; c++) @(negedge clk);
    pad_txe_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (rx_count !== 16'd5) $display("FAIL stats_rx got %0d want 5", rx_count); else passed++;
    total++; if (tx_count !== 16'd3) $display("FAIL stats_tx got %0d want 3", tx_count); else passed++;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    total++; if (rx_count !== 16'd0 || tx_count !== 16'd0)
      $display("FAIL stats_clr got rx=%0d tx=%0d want 0 0", rx_count, tx_count); else passed++;
    rx_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_full_rx;
    test_reset_mid_write;
`ifdef FT245_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
